// File: rtl/phase_oscillator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | phase_oscillator: square-wave oscillator with boundary-applied phase |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module phase_oscillator #(
  parameter int PW       = 4,
  parameter int STABLE_N = 4
) (
  input  logic          sclk,
  input  logic          re_n,
  input  logic          en,
  input  logic          init_ld,
  input  logic          phase_vld,
  input  logic [PW-1:0] phase_in,
  output logic          nout,
  output logic [PW-1:0] phi_out,
  output logic          period_tick,
  output logic          stable
);

  localparam int            C_SW       = $clog2(STABLE_N + 1);
  localparam logic [PW-1:0] C_CNT_MAX  = {PW{1'b1}};
  localparam logic [C_SW-1:0] C_STAB_MAX = C_SW'(STABLE_N);

  logic [PW-1:0]   r_cnt;
  logic [PW-1:0]   r_phase_reg;
  logic [PW-1:0]   r_pend_reg;
  logic            r_pend_flag;
  logic [C_SW-1:0] r_stab_cnt;
  logic            r_nout;
  logic            r_tick;
  logic            r_stable;

  logic [PW-1:0]   w_diff;
  logic            w_boundary;
  logic [PW-1:0]   w_applied;
  logic [C_SW-1:0] w_stab_inc;

  // (cnt - phase) mod 2^PW below half a period <=> its MSB is clear
  assign w_diff     = r_cnt - r_phase_reg;
  assign w_boundary = en && (r_cnt == C_CNT_MAX);
  // A strobe landing on the boundary wins over an older pending value
  assign w_applied  = phase_vld   ? phase_in   :
                      r_pend_flag ? r_pend_reg : r_phase_reg;
  assign w_stab_inc = (r_stab_cnt == C_STAB_MAX) ? r_stab_cnt : r_stab_cnt + 1'b1;

  always_ff @(posedge sclk or negedge re_n) begin
    if (!re_n) begin
      r_cnt       <= '0;
      r_phase_reg <= '0;
      r_pend_reg  <= '0;
      r_pend_flag <= 1'b0;
      r_stab_cnt  <= '0;
      r_nout      <= 1'b0;
      r_tick      <= 1'b0;
      r_stable    <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      if (en) r_nout <= ~w_diff[PW-1];
      if (init_ld) begin
        r_phase_reg <= phase_in;
        r_cnt       <= '0;
        r_pend_flag <= 1'b0;
        r_stab_cnt  <= '0;
        r_stable    <= 1'b0;
        r_tick      <= 1'b1;
      end else begin
        if (en) r_cnt <= r_cnt + 1'b1;
        if (w_boundary) begin
          r_tick      <= 1'b1;
          r_phase_reg <= w_applied;
          r_pend_flag <= 1'b0;
          if (w_applied != r_phase_reg) begin
            r_stab_cnt <= '0;
            r_stable   <= 1'b0;
          end else begin
            r_stab_cnt <= w_stab_inc;
            r_stable   <= (w_stab_inc == C_STAB_MAX);
          end
        end else if (phase_vld) begin
          r_pend_reg  <= phase_in;
          r_pend_flag <= 1'b1;
        end
      end
    end
  end

  assign nout        = r_nout;
  assign phi_out     = r_phase_reg;
  assign period_tick = r_tick;
  assign stable      = r_stable;

endmodule
`default_nettype wire

// File: tb/tb_phase_oscillator.sv
`default_nettype none
// tb_phase_oscillator: randomized and directed checks against a cycle-level
// reference model of the phase oscillator.
module tb_phase_oscillator;

  logic       sclk = 1'b0;
  logic       re_n = 1'b0;
  logic       en = 1'b0;
  logic       init_ld = 1'b0;
  logic       phase_vld = 1'b0;
  logic [3:0] phase_in = 4'd0;
  logic       nout;
  logic [3:0] phi_out;
  logic       period_tick;
  logic       stable;

  int tests = 0;
  int fails = 0;

  // reference model state
  int m_cnt, m_phase, m_pend, m_stab;
  bit m_pend_v, m_nout, m_tick, m_stable;

  phase_oscillator #(.PW(4), .STABLE_N(4)) dut (
    .sclk(sclk), .re_n(re_n), .en(en), .init_ld(init_ld),
    .phase_vld(phase_vld), .phase_in(phase_in), .nout(nout),
    .phi_out(phi_out), .period_tick(period_tick), .stable(stable)
  );

  always #5 sclk = ~sclk;

  function automatic logic [6:0] dut_vec();
    return {nout, phi_out, period_tick, stable};
  endfunction

  function automatic logic [6:0] ref_vec();
    logic [3:0] p;
    p = m_phase[3:0];
    return {m_nout, p, m_tick, m_stable};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_phase = 0; m_pend = 0; m_stab = 0;
    m_pend_v = 0; m_nout = 0; m_tick = 0; m_stable = 0;
  endtask

  // One period = 16 cycles; a phase update only takes effect at the wrap.
  task automatic model_step();
    int applied;
    bit wrap;
    wrap = en && (m_cnt == 15);
    if (en) m_nout = (((m_cnt - m_phase) % 16 + 16) % 16) < 8;
    m_tick = init_ld || wrap;
    if (init_ld) begin
      m_phase = int'(phase_in); m_cnt = 0; m_pend_v = 0; m_stab = 0; m_stable = 0;
    end else begin
      if (en) m_cnt = (m_cnt + 1) % 16;
      if (wrap) begin
        applied = phase_vld ? int'(phase_in) : (m_pend_v ? m_pend : m_phase);
        if (applied == m_phase) begin
          if (m_stab < 4) m_stab++;
          m_stable = (m_stab == 4);
        end else begin
          m_stab = 0; m_stable = 0;
        end
        m_phase = applied; m_pend_v = 0;
      end else if (phase_vld) begin
        m_pend = int'(phase_in); m_pend_v = 1;
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge sclk);
    @(negedge sclk);
  endtask

  task automatic wait_cnt(input int v, input string tag);
    int n = 0;
    while (m_cnt != v && n < 40) begin
      cyc();
      tests++;
      if (dut_vec() !== ref_vec()) begin
        fails++;
        $display("FAIL %s_wait: got %b expected %b", tag, dut_vec(), ref_vec());
      end
      n++;
    end
    if (m_cnt != v) begin
      fails++;
      $display("FAIL %s_timeout: cnt %0d expected %0d", tag, m_cnt, v);
    end
  endtask

  task automatic test_reset();
    re_n = 1'b0; en = 1'b1;
    model_reset();
    @(negedge sclk); @(negedge sclk);
    tests++;
    if (dut_vec() !== 7'b0) begin
      fails++;
      $display("FAIL reset: got %b expected %b", dut_vec(), 7'b0);
    end
    re_n = 1'b1;
  endtask

  task automatic test_phase0();
    int highs = 0, ticks = 0;
    for (int i = 0; i < 32; i++) begin
      cyc();
      highs += int'(nout); ticks += int'(period_tick);
      tests++;
      if (dut_vec() !== ref_vec()) begin
        fails++;
        $display("FAIL phase0 cyc%0d: got %b expected %b", i, dut_vec(), ref_vec());
      end
    end
    tests++;
    if (highs != 16 || ticks != 2 || phi_out !== 4'd0) begin
      fails++;
      $display("FAIL phase0_duty: highs %0d ticks %0d phi %0d expected 16 2 0", highs, ticks, phi_out);
    end
  endtask

  task automatic test_pending();
    wait_cnt(3, "pend");
    phase_vld = 1'b1; phase_in = 4'd5;
    cyc();
    phase_vld = 1'b0; phase_in = 4'd0;
    while (m_cnt != 0) begin
      tests++;
      if (phi_out !== 4'd0) begin
        fails++;
        $display("FAIL pend_early: phi %0d expected 0", phi_out);
      end
      cyc();
    end
    for (int i = 0; i < 18; i++) begin
      tests++;
      if (dut_vec() !== ref_vec() || phi_out !== 4'd5) begin
        fails++;
        $display("FAIL pend_applied: got %b expected %b (phi 5)", dut_vec(), ref_vec());
      end
      cyc();
    end
  endtask

  task automatic test_last_wins();
    wait_cnt(2, "last");
    phase_vld = 1'b1; phase_in = 4'd3; cyc(); phase_vld = 1'b0;
    wait_cnt(10, "last");
    phase_vld = 1'b1; phase_in = 4'd9; cyc(); phase_vld = 1'b0;
    wait_cnt(0, "last");
    tests++;
    if (phi_out !== 4'd9 || dut_vec() !== ref_vec()) begin
      fails++;
      $display("FAIL last_wins: phi %0d expected 9", phi_out);
    end
  endtask

  task automatic test_boundary_vld();
    wait_cnt(15, "bnd");
    phase_vld = 1'b1; phase_in = 4'd7; cyc(); phase_vld = 1'b0;
    tests++;
    if (phi_out !== 4'd7 || period_tick !== 1'b1 || dut.r_pend_flag !== 1'b0) begin
      fails++;
      $display("FAIL boundary_vld: phi %0d tick %b pend %b expected 7 1 0",
               phi_out, period_tick, dut.r_pend_flag);
    end
  endtask

  task automatic test_init_ld();
    wait_cnt(2, "init");
    phase_vld = 1'b1; phase_in = 4'd4; cyc(); phase_vld = 1'b0;
    wait_cnt(6, "init");
    init_ld = 1'b1; phase_in = 4'd12; cyc(); init_ld = 1'b0; phase_in = 4'd0;
    tests++;
    if (phi_out !== 4'd12 || period_tick !== 1'b1 || dut.r_cnt !== 4'd0) begin
      fails++;
      $display("FAIL init_ld: phi %0d tick %b cnt %0d expected 12 1 0",
               phi_out, period_tick, dut.r_cnt);
    end
    for (int i = 0; i < 40; i++) begin
      cyc();
      tests++;
      if (dut_vec() !== ref_vec() || phi_out !== 4'd12) begin
        fails++;
        $display("FAIL init_hold: got %b expected %b (phi 12)", dut_vec(), ref_vec());
      end
    end
  endtask

  task automatic test_stable();
    wait_cnt(5, "stab");
    init_ld = 1'b1; phase_in = 4'd2; cyc(); init_ld = 1'b0;
    for (int b = 1; b <= 4; b++) begin
      wait_cnt(15, "stab");
      cyc();
      tests++;
      if (stable !== (b == 4)) begin
        fails++;
        $display("FAIL stable_b%0d: got %b expected %b", b, stable, (b == 4));
      end
    end
    wait_cnt(4, "stab");
    phase_vld = 1'b1; phase_in = 4'd6; cyc(); phase_vld = 1'b0;
    wait_cnt(15, "stab");
    tests++;
    if (stable !== 1'b1) begin
      fails++;
      $display("FAIL stable_hold: got %b expected 1", stable);
    end
    cyc();
    tests++;
    if (stable !== 1'b0 || phi_out !== 4'd6) begin
      fails++;
      $display("FAIL stable_drop: stable %b phi %0d expected 0 6", stable, phi_out);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      en        = ($urandom_range(0, 9) != 0);
      phase_vld = ($urandom_range(0, 7) == 0);
      init_ld   = ($urandom_range(0, 59) == 0);
      phase_in  = ($urandom_range(0, 1) == 0) ? 4'(m_phase) : 4'($urandom_range(0, 15));
      cyc();
      tests++;
      if (dut_vec() !== ref_vec()) begin
        fails++;
        $display("FAIL random cyc%0d: got %b expected %b", i, dut_vec(), ref_vec());
      end
    end
    en = 1'b1; phase_vld = 1'b0; init_ld = 1'b0;
  endtask

  task automatic test_reset_mid();
    wait_cnt(3, "rmid");
    phase_vld = 1'b1; phase_in = 4'd11; cyc(); phase_vld = 1'b0;
    wait_cnt(7, "rmid");
    #2 re_n = 1'b0;
    model_reset();
    #1;
    tests++;
    if (dut_vec() !== 7'b0 || dut.r_pend_flag !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid: got %b pend %b expected 0", dut_vec(), dut.r_pend_flag);
    end
    @(negedge sclk); @(negedge sclk);
    re_n = 1'b1;
    for (int i = 0; i < 36; i++) begin
      cyc();
      tests++;
      if (dut_vec() !== ref_vec()) begin
        fails++;
        $display("FAIL reset_resume cyc%0d: got %b expected %b", i, dut_vec(), ref_vec());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_phase0();
    test_pending();
    test_last_wins();
    test_boundary_vld();
    test_init_ld();
    test_stable();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
